// File: rtl/vga_timing_generator.sv
// Raster timing generator: pixel position, visible/blank flags, sync pulses, line/frame start strobes.
// Zero latency: every output decodes the current counters; i_pixel_en gates the advance (no backpressure).
// Optional: define VGA_TIMING_LOOKAHEAD_EN to add o_next_x/o_next_y/o_next_visible for one-cycle-latency renderers.
module vga_timing_generator #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int BIT_DEPTH = 11
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_pixel_en,
    output logic [BIT_DEPTH-1:0] o_x,
    output logic [BIT_DEPTH-1:0] o_y,
    output logic                 o_visible,
    output logic                 o_hsync,
    output logic                 o_vsync,
    output logic                 o_vblank,
    output logic                 o_line_start,
`ifdef VGA_TIMING_LOOKAHEAD_EN
    output logic [BIT_DEPTH-1:0] o_next_x,
    output logic [BIT_DEPTH-1:0] o_next_y,
    output logic                 o_next_visible,
`endif
    output logic                 o_frame_start
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [BIT_DEPTH-1:0] H_LAST       = BIT_DEPTH'(H_TOTAL - 1);
    localparam logic [BIT_DEPTH-1:0] V_LAST       = BIT_DEPTH'(V_TOTAL - 1);
    localparam logic [BIT_DEPTH-1:0] H_VIS        = BIT_DEPTH'(H_VISIBLE);
    localparam logic [BIT_DEPTH-1:0] V_VIS        = BIT_DEPTH'(V_VISIBLE);
    localparam logic [BIT_DEPTH-1:0] H_SYNC_FIRST = BIT_DEPTH'(H_VISIBLE + H_FRONT);
    localparam logic [BIT_DEPTH-1:0] H_SYNC_LAST  = BIT_DEPTH'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [BIT_DEPTH-1:0] V_SYNC_FIRST = BIT_DEPTH'(V_VISIBLE + V_FRONT);
    localparam logic [BIT_DEPTH-1:0] V_SYNC_LAST  = BIT_DEPTH'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    // Sync ranges are compared inclusively so a zero back porch at full counter range cannot wrap to 0.
    if (H_TOTAL > (1 << BIT_DEPTH) || V_TOTAL > (1 << BIT_DEPTH)) begin : g_bad_params
        $error("vga_timing_generator: H_TOTAL/V_TOTAL do not fit in BIT_DEPTH bits");
    end

    logic [BIT_DEPTH-1:0] r_x;
    logic [BIT_DEPTH-1:0] r_y;
    logic [BIT_DEPTH-1:0] next_x;
    logic [BIT_DEPTH-1:0] next_y;
    logic                 in_hsync;
    logic                 in_vsync;

    always_comb begin
        next_x = r_x + BIT_DEPTH'(1);
        next_y = r_y;
        if (r_x == H_LAST) begin
            next_x = '0;
            next_y = (r_y == V_LAST) ? '0 : r_y + BIT_DEPTH'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_pixel_en) begin
            r_x <= next_x;
            r_y <= next_y;
        end
    end

    assign in_hsync = (r_x >= H_SYNC_FIRST) && (r_x <= H_SYNC_LAST);
    assign in_vsync = (r_y >= V_SYNC_FIRST) && (r_y <= V_SYNC_LAST);

    assign o_x           = r_x;
    assign o_y           = r_y;
    assign o_visible     = (r_x < H_VIS) && (r_y < V_VIS);
    assign o_vblank      = (r_y >= V_VIS);
    assign o_hsync       = in_hsync ? HSYNC_POL : ~HSYNC_POL;
    assign o_vsync       = in_vsync ? VSYNC_POL : ~VSYNC_POL;
    // Gating with i_pixel_en keeps the strobes one clock wide under a divided pixel rate.
    assign o_line_start  = i_pixel_en && (r_x == '0) && !i_reset;
    assign o_frame_start = o_line_start && (r_y == '0);

`ifdef VGA_TIMING_LOOKAHEAD_EN
    assign o_next_x       = next_x;
    assign o_next_y       = next_y;
    assign o_next_visible = (next_x < H_VIS) && (next_y < V_VIS);
`endif
endmodule

// File: tb/tb_vga_timing_generator.sv
// Randomized check of vga_timing_generator against a pixel-count model of the raster, plus pinned literal positions.
module tb_vga_timing_generator;
    localparam int HV = 16, HF = 2, HS = 3, HB = 4;
    localparam int VV = 8,  VF = 1, VS = 2, VB = 2;
    localparam int HT = HV + HF + HS + HB;   // 25
    localparam int VT = VV + VF + VS + VB;   // 13
    localparam int BD = 6;
    localparam bit HP = 1'b1;
    localparam bit VP = 1'b0;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pen = 1'b0;
    logic [BD-1:0] o_x, o_y;
    logic          o_visible, o_hsync, o_vsync, o_vblank, o_line_start, o_frame_start;
`ifdef VGA_TIMING_LOOKAHEAD_EN
    logic [BD-1:0] o_next_x, o_next_y;
    logic          o_next_visible;
`endif

    always #5 clk = ~clk;

    vga_timing_generator #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .HSYNC_POL(HP), .VSYNC_POL(VP), .BIT_DEPTH(BD)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_pixel_en(pen),
        .o_x(o_x), .o_y(o_y), .o_visible(o_visible), .o_hsync(o_hsync),
        .o_vsync(o_vsync), .o_vblank(o_vblank), .o_line_start(o_line_start),
`ifdef VGA_TIMING_LOOKAHEAD_EN
        .o_next_x(o_next_x), .o_next_y(o_next_y), .o_next_visible(o_next_visible),
`endif
        .o_frame_start(o_frame_start)
    );

    int n = 0;            // pixels elapsed since frame start (model state)
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int prev_ls = -1;
    bit div4_phase = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at n=%0d: got %0d, expected %0d", name, n, act, exp);
        end
    endtask

    task automatic compare_all();
        int x, y, nx, ny;
        bit ls;
        x  = n % HT;
        y  = (n / HT) % VT;
        nx = (n + 1) % HT;
        ny = ((n + 1) / HT) % VT;
        ls = pen && (x == 0) && !rst;
        chk("x", o_x, x);
        chk("y", o_y, y);
        chk("visible", o_visible, (x < HV && y < VV) ? 1 : 0);
        chk("vblank", o_vblank, (y >= VV) ? 1 : 0);
        chk("hsync", o_hsync, (x >= HV + HF && x < HV + HF + HS) ? HP : !HP);
        chk("vsync", o_vsync, (y >= VV + VF && y < VV + VF + VS) ? VP : !VP);
        chk("line_start", o_line_start, ls);
        chk("frame_start", o_frame_start, (ls && y == 0) ? 1 : 0);
`ifdef VGA_TIMING_LOOKAHEAD_EN
        chk("next_x", o_next_x, nx);
        chk("next_y", o_next_y, ny);
        chk("next_visible", o_next_visible, (nx < HV && ny < VV) ? 1 : 0);
`else
        if (nx < 0 || ny < 0) $display("model position negative");
`endif
    endtask

    task automatic cycle(input logic r, input logic p);
        rst = r;
        pen = p;
        #1;
        if (rst) n = 0;
        compare_all();
        if (div4_phase && o_line_start) begin
            if (prev_ls >= 0) chk("line_period_div4", cyc - prev_ls, 100);
            prev_ls = cyc;
        end
        @(posedge clk);
        if (rst) n = 0;
        else if (pen) n = (n + 1) % (HT * VT);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        // Reset values.
        rst = 1'b1; pen = 1'b1; #1;
        chk("rst_x", o_x, 0);
        chk("rst_y", o_y, 0);
        chk("rst_visible", o_visible, 1);
        chk("rst_hsync", o_hsync, 0);
        chk("rst_vsync", o_vsync, 1);
        chk("rst_line_start", o_line_start, 0);
        chk("rst_frame_start", o_frame_start, 0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'($urandom_range(0, 1)));

        // First enabled cycle after release presents frame_start at (0,0).
        rst = 1'b0; pen = 1'b1; #1;
        chk("first_frame_start", o_frame_start, 1);
        for (int i = 0; i < 18; i++) cycle(1'b0, 1'b1);
        chk("pin_x18", o_x, 18);
        chk("pin_hsync_on", o_hsync, 1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
        chk("pin_hsync_off", o_hsync, 0);
        while (n != 9 * HT) cycle(1'b0, 1'b1);
        chk("pin_vsync_on_y9", o_vsync, 0);
        while (n != HT * VT - 1) cycle(1'b0, 1'b1);
        chk("pin_last_x", o_x, 24);
        chk("pin_last_y", o_y, 12);
        chk("pin_last_vblank", o_vblank, 1);
`ifdef VGA_TIMING_LOOKAHEAD_EN
        chk("pin_next_x_wrap", o_next_x, 0);
        chk("pin_next_y_wrap", o_next_y, 0);
        chk("pin_next_vis_wrap", o_next_visible, 1);
`endif
        cycle(1'b0, 1'b1);
        rst = 1'b0; pen = 1'b1; #1;
        chk("wrap_x", o_x, 0);
        chk("wrap_y", o_y, 0);
        chk("wrap_frame_start", o_frame_start, 1);
        chk("wrap_visible", o_visible, 1);
        chk("wrap_vblank", o_vblank, 0);

        // Mid-frame asynchronous reset at (20,7), inside the hsync pulse.
        while (n != 7 * HT + 20) cycle(1'b0, 1'b1);
        rst = 1'b1; #1;
        chk("midrst_x", o_x, 0);
        chk("midrst_y", o_y, 0);
        chk("midrst_hsync", o_hsync, 0);
        chk("midrst_line_start", o_line_start, 0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1);

        // Pixel enable one clock in four: line takes 4*HT clocks.
        div4_phase = 1'b1;
        for (int i = 0; i < 4 * HT * 4; i++) cycle(1'b0, (i % 4) == 0);
        div4_phase = 1'b0;

        // Random enable pattern with rare reset pulses.
        for (int i = 0; i < 1500; i++)
            cycle(($urandom_range(0, 299) == 0), 1'($urandom_range(0, 3) != 0));
        for (int i = 0; i < 2 * HT * VT; i++) cycle(1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
